// File: rtl/ctrl_pkg.sv
// Shared control constants for the multicycle datapath: state codes, opcodes,
// special funct codes, ALU operation codes and the control-vector layout.
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IF  = 3'b000,
      ST_ID  = 3'b001,
      ST_EX  = 3'b010,
      ST_MEM = 3'b011,
      ST_WB  = 3'b100
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_MULT = 6'b011000;

   // ALU control codes; ALUOP_FUNCT defers the operation to the funct field
   localparam logic [2:0] ALUOP_FUNCT = 3'b010;
   localparam logic [2:0] ALUOP_ADD   = 3'b110;
   localparam logic [2:0] ALUOP_SLT   = 3'b011;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_OR    = 3'b101;

   localparam logic [1:0] PCSRC_SEQ  = 2'b00;
   localparam logic [1:0] PCSRC_BR   = 2'b01;
   localparam logic [1:0] PCSRC_JMP  = 2'b10;
   localparam logic [1:0] PCSRC_REG  = 2'b11;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM4 = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic       illegal;
      logic [1:0] pc_src;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
   } ctrl_t;

   function automatic logic is_legal(input logic [5:0] op);
      return op inside {OP_RTYPE, OP_ADDI, OP_SLTI, OP_ORI,
                        OP_LW, OP_SW, OP_BEQ, OP_J};
   endfunction

endpackage

// File: rtl/multicycle_out_dec.sv
// Combinational control-vector decode from current state and instruction fields.
// Anything not explicitly driven for a state/instruction pair stays 0.
module multicycle_out_dec
   import ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         ST_IF: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            if (mem_ready) begin
               ctrl.ir_write = 1'b1;
               ctrl.pc_write = 1'b1;
               ctrl.pc_src   = PCSRC_SEQ;
            end
         end
         ST_ID: begin
            ctrl.alu_src_b = SRCB_IMM4;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.illegal   = !is_legal(opcode);
         end
         ST_EX: begin
            case (opcode)
               OP_RTYPE: begin
                  if (funct == FN_JR) begin
                     ctrl.pc_write = 1'b1;
                     ctrl.pc_src   = PCSRC_REG;
                  end else begin
                     ctrl.alu_src_a = 1'b1;
                     ctrl.alu_src_b = SRCB_REG;
                     ctrl.alu_op    = ALUOP_FUNCT;
                  end
               end
               OP_ADDI, OP_SLTI, OP_ORI, OP_LW, OP_SW: begin
                  ctrl.alu_src_a = 1'b1;
                  ctrl.alu_src_b = SRCB_IMM;
                  ctrl.alu_op    = (opcode == OP_SLTI) ? ALUOP_SLT :
                                   (opcode == OP_ORI)  ? ALUOP_OR  : ALUOP_ADD;
               end
               OP_BEQ: begin
                  ctrl.alu_src_a = 1'b1;
                  ctrl.alu_src_b = SRCB_REG;
                  ctrl.alu_op    = ALUOP_SUB;
                  ctrl.pc_write  = zero;
                  ctrl.pc_src    = PCSRC_BR;
               end
               OP_J: begin
                  ctrl.pc_write = 1'b1;
                  ctrl.pc_src   = PCSRC_JMP;
               end
               default: ;
            endcase
         end
         ST_MEM: begin
            ctrl.mem_read  = (opcode == OP_LW);
            ctrl.mem_write = (opcode == OP_SW);
         end
         ST_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = (opcode == OP_RTYPE);
            ctrl.mem_to_reg = (opcode == OP_LW);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM (IF/ID/EX/MEM/WB) with a multi-cycle EX hold for mult.
// Memory stalls hold IF/MEM on mem_ready_i; outputs are forced low while in reset.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 4
)
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output logic       PCWrite_o,
   output logic       IRWrite_o,
   output logic       MemRead_o,
   output logic       MemWrite_o,
   output logic       RegWrite_o,
   output logic       RegDst_o,
   output logic       MemtoReg_o,
   output logic       ALUSrcA_o,
   output logic       illegal_o,
   output logic [1:0] PCSrc_o,
   output logic [1:0] ALUSrcB_o,
   output logic [2:0] ALUOp_o,
   output logic [2:0] state_o
);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] cnt;
   logic       in_mult;
   logic       mult_done;
   ctrl_t      ctrl;
   ctrl_t      ctrl_out;

   assign in_mult   = (state == ST_EX) && (opcode_i == OP_RTYPE) && (funct_i == FN_MULT);
   assign mult_done = (cnt == 4'(MUL_CYCLES - 1));

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state <= ST_IF;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= (in_mult && !mult_done) ? cnt + 4'd1 : '0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IF:  state_nxt = mem_ready_i ? ST_ID : ST_IF;
         ST_ID:  state_nxt = is_legal(opcode_i) ? ST_EX : ST_IF;
         ST_EX: begin
            case (opcode_i)
               OP_RTYPE: begin
                  if (funct_i == FN_JR)        state_nxt = ST_IF;
                  else if (in_mult && !mult_done) state_nxt = ST_EX;
                  else                         state_nxt = ST_WB;
               end
               OP_ADDI, OP_SLTI, OP_ORI: state_nxt = ST_WB;
               OP_LW, OP_SW:             state_nxt = ST_MEM;
               default:                  state_nxt = ST_IF;
            endcase
         end
         ST_MEM: begin
            if (opcode_i == OP_LW)      state_nxt = mem_ready_i ? ST_WB : ST_MEM;
            else if (opcode_i == OP_SW) state_nxt = mem_ready_i ? ST_IF : ST_MEM;
            else                        state_nxt = ST_IF;
         end
         ST_WB:   state_nxt = ST_IF;
         default: state_nxt = ST_IF;
      endcase
   end

   multicycle_out_dec u_dec (
      .state     (state),
      .opcode    (opcode_i),
      .funct     (funct_i),
      .zero      (zero_i),
      .mem_ready (mem_ready_i),
      .ctrl      (ctrl)
   );

   // Gate on reset so nothing (in particular a memory read) escapes while held.
   assign ctrl_out   = rst_i ? ctrl : '0;
   assign state_o    = rst_i ? state : ST_IF;
   assign PCWrite_o  = ctrl_out.pc_write;
   assign IRWrite_o  = ctrl_out.ir_write;
   assign MemRead_o  = ctrl_out.mem_read;
   assign MemWrite_o = ctrl_out.mem_write;
   assign RegWrite_o = ctrl_out.reg_write;
   assign RegDst_o   = ctrl_out.reg_dst;
   assign MemtoReg_o = ctrl_out.mem_to_reg;
   assign ALUSrcA_o  = ctrl_out.alu_src_a;
   assign illegal_o  = ctrl_out.illegal;
   assign PCSrc_o    = ctrl_out.pc_src;
   assign ALUSrcB_o  = ctrl_out.alu_src_b;
   assign ALUOp_o    = ctrl_out.alu_op;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its expected
// per-cycle output trace, which is then replayed against the DUT.
module tb_multicycle_ctrl;

   localparam int MULC = 4;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [5:0] opcode_i;
   logic [5:0] funct_i;
   logic       zero_i;
   logic       mem_ready_i;
   logic       PCWrite_o, IRWrite_o, MemRead_o, MemWrite_o, RegWrite_o;
   logic       RegDst_o, MemtoReg_o, ALUSrcA_o, illegal_o;
   logic [1:0] PCSrc_o, ALUSrcB_o;
   logic [2:0] ALUOp_o, state_o;

   typedef struct packed {
      logic [2:0] st;
      logic       pcw, irw, mr, mw, rw, rd, m2r, asa, ill;
      logic [1:0] pcsrc, asb;
      logic [2:0] aluop;
   } obs_t;

   typedef struct {
      logic       rdy;
      logic       z;
      logic [5:0] op;
      logic [5:0] fn;
      obs_t       e;
   } rec_t;

   obs_t obs;
   rec_t q[$];
   int   checks = 0;
   int   errors = 0;
   logic [5:0] ops [9] = '{6'b000000, 6'b001000, 6'b001010, 6'b001101, 6'b100011,
                           6'b101011, 6'b000100, 6'b000010, 6'b111111};

   multicycle_ctrl #(.MUL_CYCLES(MULC)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .funct_i(funct_i),
      .zero_i(zero_i), .mem_ready_i(mem_ready_i),
      .PCWrite_o(PCWrite_o), .IRWrite_o(IRWrite_o), .MemRead_o(MemRead_o),
      .MemWrite_o(MemWrite_o), .RegWrite_o(RegWrite_o), .RegDst_o(RegDst_o),
      .MemtoReg_o(MemtoReg_o), .ALUSrcA_o(ALUSrcA_o), .illegal_o(illegal_o),
      .PCSrc_o(PCSrc_o), .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o), .state_o(state_o)
   );

   always #5 clk_i = ~clk_i;

   assign obs = {state_o, PCWrite_o, IRWrite_o, MemRead_o, MemWrite_o, RegWrite_o,
                 RegDst_o, MemtoReg_o, ALUSrcA_o, illegal_o, PCSrc_o, ALUSrcB_o, ALUOp_o};

   task automatic chk(input string tag, input obs_t got, input obs_t exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic push(input logic rdy, input logic z, input logic [5:0] o,
                       input logic [5:0] f, input obs_t e);
      rec_t r;
      r.rdy = rdy; r.z = z; r.op = o; r.fn = f; r.e = e;
      q.push_back(r);
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expected trace of one instruction: ifw/memw = not-ready cycles before the
   // ready cycle in IF/MEM; zf = 0/1 forces zero_i, 2 randomizes it.
   task automatic gen(input logic [5:0] op, input logic [5:0] fn,
                      input int ifw, input int memw, input int zf);
      obs_t e;
      logic z;
      bit rt, jr, mul, imm, lw, sw, beq, jmp, ill;
      rt  = (op == 6'b000000);
      jr  = rt && (fn == 6'b001000);
      mul = rt && (fn == 6'b011000);
      imm = (op == 6'b001000) || (op == 6'b001010) || (op == 6'b001101);
      lw  = (op == 6'b100011);
      sw  = (op == 6'b101011);
      beq = (op == 6'b000100);
      jmp = (op == 6'b000010);
      ill = !(rt || imm || lw || sw || beq || jmp);
      for (int i = 0; i <= ifw; i++) begin
         e = '0; e.mr = 1'b1; e.asb = 2'b01; e.aluop = 3'b110;
         if (i == ifw) begin e.irw = 1'b1; e.pcw = 1'b1; end
         // opcode/funct are garbage while fetching; they must be ignored
         push(i == ifw, rbit(), 6'($urandom), 6'($urandom), e);
      end
      e = '0; e.st = 3'd1; e.asb = 2'b11; e.aluop = 3'b110; e.ill = ill;
      push(rbit(), rbit(), op, fn, e);
      if (ill) return;
      for (int i = 0; i < (mul ? MULC : 1); i++) begin
         z = (zf == 2) ? rbit() : 1'(zf);
         e = '0; e.st = 3'd2;
         if (jr) begin e.pcw = 1'b1; e.pcsrc = 2'b11; end
         else if (rt) begin e.asa = 1'b1; e.aluop = 3'b010; end
         else if (imm || lw || sw) begin
            e.asa = 1'b1; e.asb = 2'b10;
            e.aluop = (op == 6'b001010) ? 3'b011 : (op == 6'b001101) ? 3'b101 : 3'b110;
         end
         else if (beq) begin e.asa = 1'b1; e.aluop = 3'b001; e.pcw = z; e.pcsrc = 2'b01; end
         else begin e.pcw = 1'b1; e.pcsrc = 2'b10; end
         push(rbit(), z, op, fn, e);
      end
      if (lw || sw) begin
         for (int i = 0; i <= memw; i++) begin
            e = '0; e.st = 3'd3; e.mr = lw; e.mw = sw;
            push(i == memw, rbit(), op, fn, e);
         end
      end
      if ((rt && !jr) || imm || lw) begin
         e = '0; e.st = 3'd4; e.rw = 1'b1; e.rd = rt; e.m2r = lw;
         push(rbit(), rbit(), op, fn, e);
      end
   endtask

   task automatic run(input int n, input string name);
      rec_t r;
      for (int k = 0; k < n && q.size() > 0; k++) begin
         r = q.pop_front();
         mem_ready_i = r.rdy; zero_i = r.z; opcode_i = r.op; funct_i = r.fn;
         @(negedge clk_i);
         chk($sformatf("%s.c%0d", name, k), obs, r.e);
         @(posedge clk_i); #1;
      end
   endtask

   task automatic rst_cycle(input string name);
      rst_i = 1'b0;
      mem_ready_i = 1'b0;
      @(negedge clk_i);
      chk(name, obs, '0);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      q.delete();
   endtask

   initial begin
      rst_i = 1'b0; opcode_i = '0; funct_i = '0; zero_i = 1'b0; mem_ready_i = 1'b0;
      rst_cycle("reset0");
      rst_cycle("reset1");

      gen(6'b000000, 6'b100000, 0, 0, 2); run(100, "add");
      gen(6'b100011, 6'b000000, 0, 3, 2); run(100, "lw_stall");
      gen(6'b000100, 6'b000000, 0, 0, 1); run(100, "beq_taken");
      gen(6'b000100, 6'b000000, 1, 0, 0); run(100, "beq_not");
      gen(6'b000000, 6'b011000, 0, 0, 2); run(100, "mult");
      gen(6'b111111, 6'b000000, 0, 0, 2); run(100, "illegal");
      gen(6'b000010, 6'b000000, 2, 0, 2); run(100, "j");
      gen(6'b000000, 6'b001000, 0, 0, 2); run(100, "jr");
      gen(6'b001000, 6'b000000, 0, 0, 2); run(100, "addi");
      gen(6'b001010, 6'b000000, 0, 0, 2); run(100, "slti");
      gen(6'b001101, 6'b000000, 0, 0, 2); run(100, "ori");
      gen(6'b101011, 6'b000000, 0, 2, 2); run(100, "sw");

      // reset during the second mult EX cycle, then a full mult must take MULC again
      gen(6'b000000, 6'b011000, 0, 0, 2); run(3, "mult_pre");
      rst_cycle("mult_rst");
      gen(6'b000000, 6'b011000, 0, 0, 2); run(100, "mult_after");

      // reset while sw is stalled in MEM
      gen(6'b101011, 6'b000000, 0, 5, 2); run(4, "sw_pre");
      rst_cycle("sw_rst");
      gen(6'b001000, 6'b000000, 0, 0, 2); run(100, "sw_after");

      for (int n = 0; n < 80; n++) begin
         logic [5:0] op, fn;
         op = ops[$urandom_range(0, 8)];
         if (op == 6'b111111) op = 6'($urandom);
         case ($urandom_range(0, 3))
            0:       fn = 6'b100000;
            1:       fn = 6'b001000;
            2:       fn = 6'b011000;
            default: fn = 6'($urandom);
         endcase
         gen(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), 2);
         run(100, $sformatf("rnd%0d_op%b", n, op));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
